// File: rtl/multichannel_amplitude_detector.sv
// Windowed per-lane amplitude detector: tracks signed max/min over a fixed number of
// accepted samples and reports positive peak, absolute peak or half peak-to-peak.
module multichannel_amplitude_detector #(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned SAMPLE_WIDTH   = 16,
    parameter int unsigned WINDOW_SAMPLES = 256
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_enable,
    input  logic                             i_sample,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0] i_data,
    input  logic [1:0]                       i_mode,
    output logic [CHANNELS*SAMPLE_WIDTH-1:0] o_amplitude,
    output logic                             o_update,
    output logic                             o_busy
);

    localparam int unsigned SW   = SAMPLE_WIDTH;
    localparam int unsigned CntW = $clog2(WINDOW_SAMPLES + 1);

    localparam logic [CntW-1:0]      LastCnt   = CntW'(WINDOW_SAMPLES - 1);
    localparam logic signed [SW-1:0] MaxPos    = {1'b0, {(SW-1){1'b1}}};
    localparam logic signed [SW-1:0] MinNeg    = {1'b1, {(SW-1){1'b0}}};
    localparam logic signed [SW:0]   MaxPosExt = {2'b00, {(SW-1){1'b1}}};

    typedef enum logic [0:0] {StIdle, StSample} state_e;

    // Window result from the final tracker values; mode 11 falls through to positive peak.
    function automatic logic [SW-1:0] amp_calc(input logic [1:0]             mode,
                                               input logic signed [SW-1:0] mx,
                                               input logic signed [SW-1:0] mn);
        logic signed [SW:0] emx;
        logic signed [SW:0] emn;
        logic signed [SW:0] neg_mn;
        logic signed [SW:0] big;
        logic signed [SW:0] diff;
        emx    = {mx[SW-1], mx};
        emn    = {mn[SW-1], mn};
        neg_mn = -emn;
        big    = (emx > neg_mn) ? emx : neg_mn;
        diff   = emx - emn;
        case (mode)
            2'b01:   amp_calc = (big > MaxPosExt) ? MaxPos : SW'(big);
            2'b10:   amp_calc = SW'(diff >>> 1);
            default: amp_calc = mx[SW-1] ? '0 : mx;
        endcase
    endfunction

    state_e                   state_q, state_d;
    logic [1:0]               mode_q, mode_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic signed [SW-1:0]     max_q [CHANNELS];
    logic signed [SW-1:0]     max_d [CHANNELS];
    logic signed [SW-1:0]     min_q [CHANNELS];
    logic signed [SW-1:0]     min_d [CHANNELS];
    logic [CHANNELS*SW-1:0]   amp_q, amp_d;
    logic                     upd_q, upd_d;

    logic signed [SW-1:0]     lane_x   [CHANNELS];
    logic signed [SW-1:0]     upd_max  [CHANNELS];
    logic signed [SW-1:0]     upd_min  [CHANNELS];
    logic [SW-1:0]            lane_res [CHANNELS];

    // Trackers as they would stand after accepting the current sample.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        assign lane_x[g]   = i_data[g*SW +: SW];
        assign upd_max[g]  = (lane_x[g] > max_q[g]) ? lane_x[g] : max_q[g];
        assign upd_min[g]  = (lane_x[g] < min_q[g]) ? lane_x[g] : min_q[g];
        assign lane_res[g] = amp_calc(mode_q, upd_max[g], upd_min[g]);
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        min_d   = min_q;
        amp_d   = amp_q;
        upd_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_enable) begin
                    state_d = StSample;
                    mode_d  = i_mode;
                    cnt_d   = '0;
                    for (int unsigned k = 0; k < CHANNELS; k++) begin
                        max_d[k] = MinNeg;
                        min_d[k] = MaxPos;
                    end
                end
            end
            StSample: begin
                if (!i_enable) begin
                    state_d = StIdle;
                end else if (i_sample) begin
                    if (cnt_q == LastCnt) begin
                        // Close the window and open the next one on the same edge.
                        for (int unsigned k = 0; k < CHANNELS; k++) begin
                            amp_d[k*SW +: SW] = lane_res[k];
                            max_d[k]          = MinNeg;
                            min_d[k]          = MaxPos;
                        end
                        cnt_d  = '0;
                        mode_d = i_mode;
                        upd_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                        max_d = upd_max;
                        min_d = upd_min;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            mode_q  <= 2'b00;
            cnt_q   <= '0;
            amp_q   <= '0;
            upd_q   <= 1'b0;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                max_q[k] <= MinNeg;
                min_q[k] <= MaxPos;
            end
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            amp_q   <= amp_d;
            upd_q   <= upd_d;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                max_q[k] <= max_d[k];
                min_q[k] <= min_d[k];
            end
        end
    end

    assign o_amplitude = amp_q;
    assign o_update    = upd_q;
    assign o_busy      = (state_q == StSample);

endmodule

// File: tb/tb_multichannel_amplitude_detector.sv
// Bench for multichannel_amplitude_detector: directed windows with literal results plus
// random traffic, all checked each cycle against a window-list model.
module tb_multichannel_amplitude_detector;

    localparam int CH  = 2;
    localparam int SW  = 16;
    localparam int WIN = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              smp;
    logic [CH*SW-1:0]  data;
    logic [1:0]        mode;
    logic [CH*SW-1:0]  amp;
    logic              upd;
    logic              busy;

    multichannel_amplitude_detector #(
        .CHANNELS      (CH),
        .SAMPLE_WIDTH  (SW),
        .WINDOW_SAMPLES(WIN)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_enable   (en),
        .i_sample   (smp),
        .i_data     (data),
        .i_mode     (mode),
        .o_amplitude(amp),
        .o_update   (upd),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    typedef int lane_t [CH];

    int     total = 0;
    int     bad   = 0;
    int     cyc_n = 0;
    int     upd_cycles[$];
    lane_t  win[$];
    bit     open;
    int     win_mode;
    int     exp_amp [CH];
    bit     exp_upd;
    bit     exp_busy;

    function automatic void model_reset();
        open     = 1'b0;
        win_mode = 0;
        win.delete();
        foreach (exp_amp[k]) exp_amp[k] = 0;
        exp_upd  = 1'b0;
        exp_busy = 1'b0;
    endfunction

    // Result straight from the list of samples in the window.
    function automatic int window_result(int k);
        int mx, mn, peak, v, av;
        mx   = win[0][k];
        mn   = win[0][k];
        peak = 0;
        foreach (win[i]) begin
            v  = win[i][k];
            av = (v < 0) ? -v : v;
            if (v > mx) mx = v;
            if (v < mn) mn = v;
            if (av > peak) peak = av;
        end
        case (win_mode)
            1:       return (peak > 2**(SW-1) - 1) ? 2**(SW-1) - 1 : peak;
            2:       return (mx - mn) / 2;
            default: return (mx < 0) ? 0 : mx;
        endcase
    endfunction

    function automatic void model_step();
        lane_t s;
        exp_upd = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        if (!open) begin
            if (en) begin
                open     = 1'b1;
                win_mode = int'(mode);
                win.delete();
            end
        end else if (!en) begin
            open = 1'b0;
            win.delete();
        end else if (smp) begin
            foreach (s[k]) s[k] = int'($signed(data[k*SW +: SW]));
            win.push_back(s);
            if (win.size() == WIN) begin
                foreach (exp_amp[k]) exp_amp[k] = window_result(k);
                exp_upd  = 1'b1;
                win.delete();
                win_mode = int'(mode);
            end
        end
        exp_busy = open;
    endfunction

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc_n);
        end
    endtask

    function automatic int lane(int k);
        return int'(amp[k*SW +: SW]);
    endfunction

    task automatic compare_all();
        chk("update", int'(upd), int'(exp_upd));
        chk("busy", int'(busy), int'(exp_busy));
        for (int k = 0; k < CH; k++) chk($sformatf("amp%0d", k), lane(k), exp_amp[k]);
        if (upd) upd_cycles.push_back(cyc_n);
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic cyc(input bit e, input bit s, input logic [1:0] m, input int a, input int b);
        en   = e;
        smp  = s;
        mode = m;
        data = {b[SW-1:0], a[SW-1:0]};
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc_n++;
        compare_all();
    endtask

    function automatic int rnd_sample();
        int r;
        r = int'($urandom_range(0, 7));
        case (r)
            0:       return -32768;
            1:       return 32767;
            2:       return 0;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        smp  = 1'b0;
        mode = 2'b00;
        data = '0;
        model_reset();
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 1, 7, 7);
        chk("reset_amp0", lane(0), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_upd", int'(upd), 0);
        rst = 1'b0;

        // Open with i_sample high: that sample must be ignored.
        cyc(1, 1, 0, 99, 99);
        chk("open_busy", int'(busy), 1);
        cyc(1, 1, 0, 5, -8);
        cyc(1, 1, 0, -3, -2);
        cyc(1, 1, 0, 12, -9);
        cyc(1, 1, 0, 7, -1);
        chk("m00_upd", int'(upd), 1);
        chk("m00_l0", lane(0), 12);
        chk("m00_l1", lane(1), 0);

        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 1, 5, -8);
        cyc(1, 1, 1, -3, -2);
        cyc(1, 1, 1, 12, -9);
        cyc(1, 1, 1, 7, -1);
        chk("m01_l0", lane(0), 12);
        chk("m01_l1", lane(1), 9);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, -32768, 3);
        chk("m01_sat", lane(0), 32767);
        chk("m01_l1b", lane(1), 3);

        cyc(0, 0, 2, 0, 0);
        cyc(1, 0, 2, 0, 0);
        cyc(1, 1, 2, 100, 0);
        cyc(1, 1, 2, -50, 0);
        cyc(1, 1, 2, 20, 0);
        cyc(1, 1, 2, 0, 0);
        chk("m10_l0", lane(0), 75);
        cyc(1, 1, 2, 32767, 1);
        cyc(1, 1, 2, -32768, 1);
        cyc(1, 1, 2, 0, 1);
        cyc(1, 1, 2, 0, 1);
        chk("m10_full", lane(0), 32767);
        chk("m10_l1", lane(1), 0);

        // Back-to-back windows with i_sample held high.
        upd_cycles.delete();
        cyc(1, 1, 2, 1000, 0);
        cyc(1, 1, 2, -1000, 0);
        cyc(1, 1, 2, 5, 0);
        cyc(1, 1, 2, 5, 0);
        chk("b2b_first", lane(0), 1000);
        cyc(1, 1, 2, 10, 0);
        cyc(1, 1, 2, 20, 0);
        cyc(1, 1, 2, 30, 0);
        cyc(1, 1, 2, 40, 0);
        chk("b2b_second", lane(0), 15);
        chk("b2b_pulses", upd_cycles.size(), 2);
        if (upd_cycles.size() == 2) chk("b2b_spacing", upd_cycles[1] - upd_cycles[0], 4);

        // Abort after two samples, then a fresh window.
        upd_cycles.delete();
        cyc(1, 1, 2, 30000, 30000);
        cyc(1, 1, 2, 30000, 30000);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(1, 1, 0, i, -i);
        chk("abort_l0", lane(0), 4);
        chk("abort_l1", lane(1), 0);
        chk("abort_pulses", upd_cycles.size(), 1);

        // Asynchronous reset in the middle of a window.
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 5, 0);
        cyc(1, 1, 0, -3, 0);
        cyc(1, 1, 0, 12, 0);
        cyc(1, 1, 0, 7, 0);
        cyc(1, 1, 0, 1, 1);
        cyc(1, 1, 0, 1, 1);
        chk("pre_rst_amp", lane(0), 12);
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_amp", lane(0), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_upd", int'(upd), 0);
        cyc(1, 1, 0, 1, 1);
        rst = 1'b0;

        // Mode changes inside a window must not take effect.
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 2, -20, 0);
        cyc(1, 1, 2, 5, 0);
        cyc(1, 1, 2, 3, 0);
        cyc(1, 1, 2, 1, 0);
        chk("mode_latched", lane(0), 20);

        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) < 6),
                2'($urandom_range(0, 3)), rnd_sample(), rnd_sample());
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                model_reset();
                #2;
                rst = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multichannel_amplitude_detector.md
MULTICHANNEL_AMPLITUDE_DETECTOR -- requirements
Module: multichannel_amplitude_detector

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent signed sample lanes; valid range 1..8.
REQ-002 Parameter SAMPLE_WIDTH, default 16: bits per lane sample and per lane amplitude; valid range 4..32.
REQ-003 Parameter WINDOW_SAMPLES, default 256: accepted samples per detection window; valid range 2..65536.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset; the clock port is i_clock and the reset port is i_reset.
REQ-005 i_clock  input  1  rising-edge clock for all state.
REQ-006 i_reset  input  1  asynchronous, active-high reset.
REQ-007 i_enable  input  1  high: detection runs; low: block idles and aborts any open window.
REQ-008 i_sample  input  1  single-cycle qualifier; i_data is accepted on cycles where it is high.
REQ-009 i_data  input  CHANNELS*SAMPLE_WIDTH  lane k is bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH], two's complement.
REQ-010 i_mode  input  2  00 positive peak, 01 absolute peak, 10 half peak-to-peak, 11 reserved (behaves as 00).
REQ-011 o_amplitude  output  CHANNELS*SAMPLE_WIDTH  last completed window result per lane, same lane packing as i_data.
REQ-012 o_update  output  1  one-cycle pulse coincident with the first cycle o_amplitude shows a new result.
REQ-013 o_busy  output  1  high while a window is open (state SAMPLE).

Function
REQ-014 The FSM SHALL have two states: IDLE and SAMPLE.
REQ-015 IDLE -> SAMPLE on any cycle with i_enable high; in that transition the mode register latches i_mode, trackers are initialised and the sample counter is cleared.
REQ-016 SAMPLE -> IDLE on any cycle with i_enable low; the partial window is discarded, no o_update is produced, and o_amplitude holds its value.
REQ-017 i_sample in IDLE, or on the IDLE -> SAMPLE transition cycle, SHALL be ignored.
REQ-018 Per lane, trackers SHALL initialise as max = most negative value and min = most positive value.
REQ-019 Each accepted sample SHALL update max = larger(max, x) and min = smaller(min, x), compared as signed values.
REQ-020 On the cycle the WINDOW_SAMPLES-th sample is accepted:
- results are computed including that sample and registered into o_amplitude at that clock edge
- trackers and the counter are re-initialised and i_mode is re-latched; the FSM stays in SAMPLE
- the next window starts with no gap
REQ-021 o_update SHALL be high for exactly the cycle after that edge; latency from final accepted sample to o_update and new o_amplitude is 1 cycle.
REQ-022 Mode 00 result = max clamped below at 0.
REQ-023 Mode 01 result = larger(max, -min), computed in SAMPLE_WIDTH+1 bits and saturated to 2^(SAMPLE_WIDTH-1)-1.
REQ-024 Mode 10 result = (max - min) computed in SAMPLE_WIDTH+1 bits, arithmetic shift right by 1; always non-negative and always fits.
REQ-025 Changes of i_mode within an open window SHALL have no effect until the next window start.
REQ-026 All lanes SHALL share one counter and one o_update; lanes are otherwise independent.
REQ-027 The sample counter SHALL be $clog2(WINDOW_SAMPLES+1) bits wide and SHALL never exceed WINDOW_SAMPLES-1 while in SAMPLE.

Reset
REQ-028 While i_reset is high, the block SHALL hold the reset values: state IDLE; o_amplitude, o_update, o_busy and the counter 0; trackers initialised per REQ-018; mode 00.
REQ-029 A reset asserted mid-window SHALL discard the window immediately (asynchronously) with no o_update.
REQ-030 After reset release, the first window opens on the first clock with i_enable high.

Verification
REQ-031 CHANNELS=2, SAMPLE_WIDTH=16, WINDOW_SAMPLES=4, mode 00; lane0 = 5,-3,12,7; lane1 = -8,-2,-9,-1 -> one-cycle o_update, lane0 = 12, lane1 = 0.
REQ-032 Same stimulus, mode 01 -> lane0 = 12, lane1 = 9; lane0 = -32768 only (four samples) -> 32767, saturated.
REQ-033 Mode 10; lane0 = 100,-50,20,0 -> 75; lane0 = 32767,-32768,0,0 -> 32767.
REQ-034 Back-to-back windows with i_sample held high for 8 cycles -> o_update pulses exactly 4 cycles apart; the second result reflects samples 5-8 only.
REQ-035 i_enable dropped after 2 of 4 samples, then raised and 4 fresh samples given -> no o_update for the partial window; output reflects only the fresh 4.
REQ-036 i_reset pulsed mid-window with o_amplitude = 12 -> o_amplitude = 0, o_busy = 0, no o_update, with no clock edge needed; i_mode toggled mid-window -> result uses the mode latched at window start.
